// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares one single-port RAM (registered read data)
// between two requesters. The grant is combinational and the RAM path is a
// plain mux. Read data is steered back to the issuing requester through a
// RD_LATENCY-deep valid/tag pipeline.
// Default arbitration is round-robin with at most MAX_BURST consecutive
// grants to one owner while the other requester waits.
// Optional macro ARB_FIXED_PRIORITY_EN: requester 0 gets strict priority.
module ram_access_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 8,
    parameter int MAX_BURST  = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic              CLOCK_50_I,
    input  logic              RESET_I,
    input  logic              REQ0_I,
    input  logic              WE0_I,
    input  logic [ADDR_W-1:0] ADDR0_I,
    input  logic [DATA_W-1:0] WDATA0_I,
    output logic              GNT0_O,
    output logic              RVALID0_O,
    output logic [DATA_W-1:0] RDATA0_O,
    input  logic              REQ1_I,
    input  logic              WE1_I,
    input  logic [ADDR_W-1:0] ADDR1_I,
    input  logic [DATA_W-1:0] WDATA1_I,
    output logic              GNT1_O,
    output logic              RVALID1_O,
    output logic [DATA_W-1:0] RDATA1_O,
    output logic [ADDR_W-1:0] RAM_ADDR_O,
    output logic [DATA_W-1:0] RAM_WDATA_O,
    output logic              RAM_WE_O,
    input  logic [DATA_W-1:0] RAM_RDATA_I
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] LP_MAX_BURST = 4'(MAX_BURST);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_burst_cnt;
    logic [3:0]      w_burst_nxt;
    logic [3:0]      w_burst_inc;
    logic            w_below_max;
    logic            r_last_served;
    logic            w_last_nxt;
    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_rd_push;
    logic [RD_LATENCY-1:0] r_vld;
    logic [RD_LATENCY-1:0] r_tag;
    logic            w_rv0;
    logic            w_rv1;

    assign w_below_max = (r_burst_cnt < LP_MAX_BURST);
    assign w_burst_inc = w_below_max ? (r_burst_cnt + 4'd1) : r_burst_cnt;

    // Grant decision and next owner/burst/last-served state
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = ST_IDLE;
        w_burst_nxt = '0;
        w_last_nxt  = r_last_served;

        if (!RESET_I) begin
`ifdef ARB_FIXED_PRIORITY_EN
            w_gnt0 = REQ0_I;
            w_gnt1 = REQ1_I && !REQ0_I;
`else
            case (r_state)
                ST_OWN0: begin
                    if (REQ0_I && (!REQ1_I || w_below_max)) w_gnt0 = 1'b1;
                    else if (REQ1_I)                        w_gnt1 = 1'b1;
                end
                ST_OWN1: begin
                    if (REQ1_I && (!REQ0_I || w_below_max)) w_gnt1 = 1'b1;
                    else if (REQ0_I)                        w_gnt0 = 1'b1;
                end
                default: begin
                    if (REQ0_I && REQ1_I) begin
                        w_gnt0 = r_last_served;
                        w_gnt1 = !r_last_served;
                    end else begin
                        w_gnt0 = REQ0_I;
                        w_gnt1 = REQ1_I;
                    end
                end
            endcase
`endif
        end

        if (w_gnt0) begin
            w_state_nxt = ST_OWN0;
            w_last_nxt  = 1'b0;
            w_burst_nxt = (r_state == ST_OWN0) ? w_burst_inc : 4'd1;
        end else if (w_gnt1) begin
            w_state_nxt = ST_OWN1;
            w_last_nxt  = 1'b1;
            w_burst_nxt = (r_state == ST_OWN1) ? w_burst_inc : 4'd1;
        end
    end

    // Owner state register; requester 0 wins the first tie after reset
    always_ff @(posedge CLOCK_50_I) begin
        if (RESET_I) begin
            r_state       <= ST_IDLE;
            r_burst_cnt   <= '0;
            r_last_served <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_burst_cnt   <= w_burst_nxt;
            r_last_served <= w_last_nxt;
        end
    end

    assign w_rd_push = (w_gnt0 && !WE0_I) || (w_gnt1 && !WE1_I);

    // Read-return pipeline: valid bit plus requester tag, aligned to RAM latency
    always_ff @(posedge CLOCK_50_I) begin
        if (RESET_I) begin
            r_vld <= '0;
            r_tag <= '0;
        end else begin
            r_vld[0] <= w_rd_push;
            r_tag[0] <= w_gnt1;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_rv0 = !RESET_I && r_vld[RD_LATENCY-1] && !r_tag[RD_LATENCY-1];
    assign w_rv1 = !RESET_I && r_vld[RD_LATENCY-1] &&  r_tag[RD_LATENCY-1];

    assign GNT0_O    = w_gnt0;
    assign GNT1_O    = w_gnt1;
    assign RVALID0_O = w_rv0;
    assign RVALID1_O = w_rv1;
    assign RDATA0_O  = w_rv0 ? RAM_RDATA_I : '0;
    assign RDATA1_O  = w_rv1 ? RAM_RDATA_I : '0;

    assign RAM_ADDR_O  = w_gnt0 ? ADDR0_I  : (w_gnt1 ? ADDR1_I  : '0);
    assign RAM_WDATA_O = w_gnt0 ? WDATA0_I : (w_gnt1 ? WDATA1_I : '0);
    assign RAM_WE_O    = (w_gnt0 && WE0_I) || (w_gnt1 && WE1_I);

endmodule
